value_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit button press counter.
- Watches the counter's `value` bus and detects every change.
- Sends the newest value as one raw byte on a UART TX line: 8N1, LSB first, fixed baud divider.
- If the value changes while a frame is in flight, changes are merged and only the latest value is queued for the next frame.

---
 rtl/value_uart_tx.sv | 137 +++++++++++++
 tb/tb_value_uart_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/value_uart_tx.sv
// value_uart_tx: sends each new counter value as one 8N1 UART byte.
// Changes that arrive while a frame is in flight are merged, and only the
// latest value is queued for the next frame.
module value_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic       tx,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             tx_n, busy_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             pending, pending_n;
  logic [7:0]       snapshot, snapshot_n;
  logic [7:0]       last_value, last_value_n;
  logic             baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // State and output registers; last_value tracks value during reset so the
  // value present at reset release is not sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pending    <= 1'b0;
      snapshot   <= '0;
      last_value <= value;
    end else begin
      state      <= state_n;
      tx         <= tx_n;
      busy       <= busy_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      pending    <= pending_n;
      snapshot   <= snapshot_n;
      last_value <= last_value_n;
    end
  end

  // Next-state logic: frame sequencing, then change detect (which wins over
  // the pending clear in IDLE so a same-cycle change is never lost).
  always_comb begin
    state_n      = state;
    tx_n         = tx;
    busy_n       = busy;
    baud_cnt_n   = baud_cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    pending_n    = pending;
    snapshot_n   = snapshot;
    last_value_n = last_value;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (pending) begin
          shreg_n    = snapshot;
          pending_n  = 1'b0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tx_n       = shreg[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    if (value != last_value) begin
      last_value_n = value;
      snapshot_n   = value;
      pending_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_value_uart_tx.sv
// Directed testbench for value_uart_tx (CLKS_PER_BIT=4 instance plus one
// default-baud instance checked by a UART receiver model).
module tb_value_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic [7:0] value_d;
  logic       tx, busy;
  logic       tx_d, busy_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  value_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .tx   (tx),
    .busy (busy)
  );

  value_uart_tx dut_def (
    .clk  (clk),
    .rst  (rst),
    .value(value_d),
    .tx   (tx_d),
    .busy (busy_d)
  );

  // Advance one clock; everything is driven and sampled 1 ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a new value and observe tx/busy after edges k and k+1.
  task automatic launch(input logic [7:0] v, output logic tx_k, output logic busy_k,
                        output logic tx_k1, output logic busy_k1);
    value = v;
    step();
    tx_k   = tx;
    busy_k = busy;
    step();
    tx_k1   = tx;
    busy_k1 = busy;
  endtask

  // Record one frame starting at its first start-bit cycle: mid-bit samples
  // (first sample ends in bits[0]) and the busy length. Optional value
  // changes are applied at the given frame cycles (-1 disables a slot).
  task automatic capture(input int t0, input logic [7:0] v0,
                         input int t1, input logic [7:0] v1,
                         input int t2, input logic [7:0] v2,
                         output logic [9:0] bits, output int blen);
    bits = '0;
    blen = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy !== 1'b1) break;
      if ((c % 4) == 2 && c < 40) bits = {tx, bits[9:1]};
      blen++;
      if (c == t0) value = v0;
      if (c == t1) value = v1;
      if (c == t2) value = v2;
      step();
    end
  endtask

  // Look for a falling tx within a bounded number of cycles.
  task automatic wait_fall(input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    value   = 8'h00;
    value_d = 8'h00;
    repeat (3) step();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      total++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
      end
    end
  endtask

  task automatic test_single();
    logic a, b, c, d;
    logic [9:0] bits;
    int blen;
    bit found;
    launch(8'h01, a, b, c, d);
    total++;
    if ({a, b, c, d} !== 4'b1001) begin
      bad++;
      $display("FAIL single_latency: tx_k,busy_k,tx_k1,busy_k1=%b want 1001", {a, b, c, d});
    end
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0001_0) begin
      bad++;
      $display("FAIL single_bits: got %b want %b", bits, 10'b1_0000_0001_0);
    end
    total++;
    if (blen !== 40) begin
      bad++;
      $display("FAIL single_busy_len: got %0d want 40", blen);
    end
    wait_fall(60, found);
    total++;
    if (found !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_no_extra: found=%b busy=%b want 0 0", found, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic a, b, c, d;
    logic [9:0] bits;
    int blen;
    bit found;
    rst   = 1'b1;
    value = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    step();
    launch(8'h01, a, b, c, d);
    total++;
    if ({a, b, c, d} !== 4'b1001) begin
      bad++;
      $display("FAIL b2b_latency: got %b want 1001", {a, b, c, d});
    end
    capture(5, 8'h02, 15, 8'h03, 25, 8'h04, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0001_0 || blen !== 40) begin
      bad++;
      $display("FAIL b2b_frame1: bits=%b len=%0d want %b len=40", bits, blen, 10'b1_0000_0001_0);
    end
    // Cycle 40 is the single idle cycle; tx must drop on the next edge.
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle_cycle: tx=%b want 1", tx);
    end
    step();
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0100_0 || blen !== 40) begin
      bad++;
      $display("FAIL b2b_frame2: bits=%b len=%0d want %b len=40", bits, blen, 10'b1_0000_0100_0);
    end
    wait_fall(60, found);
    total++;
    if (found !== 1'b0) begin
      bad++;
      $display("FAIL b2b_single_followup: extra frame found=%b want 0", found);
    end
  endtask

  task automatic test_coalesce_same();
    logic a, b, c, d;
    logic [9:0] bits;
    int blen;
    bit found;
    launch(8'h05, a, b, c, d);
    capture(8, 8'h06, 20, 8'h05, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0101_0 || blen !== 40) begin
      bad++;
      $display("FAIL coal_frame1: bits=%b len=%0d want %b len=40", bits, blen, 10'b1_0000_0101_0);
    end
    step();
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL coal_followup_start: tx=%b busy=%b want 0 1", tx, busy);
    end
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0101_0) begin
      bad++;
      $display("FAIL coal_frame2: bits=%b want %b", bits, 10'b1_0000_0101_0);
    end
    wait_fall(60, found);
    total++;
    if (found !== 1'b0) begin
      bad++;
      $display("FAIL coal_no_third: found=%b want 0", found);
    end
  endtask

  task automatic test_wrap();
    logic a, b, c, d;
    logic [9:0] bits;
    int blen;
    launch(8'hFF, a, b, c, d);
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_1111_1111_0) begin
      bad++;
      $display("FAIL wrap_ff: bits=%b want %b", bits, 10'b1_1111_1111_0);
    end
    repeat (10) step();
    launch(8'h00, a, b, c, d);
    total++;
    if ({a, b, c, d} !== 4'b1001) begin
      bad++;
      $display("FAIL wrap_latency: got %b want 1001", {a, b, c, d});
    end
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_0000_0000_0 || blen !== 40) begin
      bad++;
      $display("FAIL wrap_00: bits=%b len=%0d want %b len=40", bits, blen, 10'b1_0000_0000_0);
    end
  endtask

  task automatic test_reset_mid();
    logic a, b, c, d;
    logic [9:0] bits;
    int blen;
    bit found;
    repeat (10) step();
    launch(8'hA5, a, b, c, d);
    repeat (17) step();
    // Frame cycle 17 lies inside data bit 3, which is 0 for 0xA5.
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_bit3: tx=%b busy=%b want 0 1", tx, busy);
    end
    rst   = 1'b1;
    value = 8'hA6;
    step();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort: tx=%b busy=%b want 1 0", tx, busy);
    end
    rst = 1'b0;
    step();
    wait_fall(60, found);
    total++;
    if (found !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_frame: found=%b busy=%b want 0 0", found, busy);
    end
    launch(8'hA7, a, b, c, d);
    total++;
    if ({a, b, c, d} !== 4'b1001) begin
      bad++;
      $display("FAIL mid_relaunch: got %b want 1001", {a, b, c, d});
    end
    capture(-1, 8'h00, -1, 8'h00, -1, 8'h00, bits, blen);
    total++;
    if (bits !== 10'b1_1010_0111_0 || blen !== 40) begin
      bad++;
      $display("FAIL mid_frame: bits=%b len=%0d want %b len=40", bits, blen, 10'b1_1010_0111_0);
    end
  endtask

  task automatic test_default_baud();
    logic [7:0] rx;
    bit found;
    found   = 1'b0;
    rx      = '0;
    value_d = 8'h55;
    for (int c = 0; c < 10; c++) begin
      step();
      if (tx_d === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (found !== 1'b1) begin
      bad++;
      $display("FAIL def_start_timeout: no start bit within 10 cycles");
    end else begin
      repeat (217) step();
      total++;
      if (tx_d !== 1'b0) begin
        bad++;
        $display("FAIL def_start_mid: tx=%b want 0", tx_d);
      end
      for (int i = 0; i < 8; i++) begin
        repeat (434) step();
        rx = {tx_d, rx[7:1]};
      end
      total++;
      if (rx !== 8'h55) begin
        bad++;
        $display("FAIL def_rx_byte: got %h want 55", rx);
      end
      repeat (434) step();
      total++;
      if (tx_d !== 1'b1) begin
        bad++;
        $display("FAIL def_stop_bit: tx=%b want 1 (framing)", tx_d);
      end
      found = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (busy_d === 1'b0) begin
          found = 1'b1;
          break;
        end
        step();
      end
      total++;
      if (found !== 1'b1) begin
        bad++;
        $display("FAIL def_busy_end: busy still high after frame");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_coalesce_same();
    test_wrap();
    test_reset_mid();
    test_default_baud();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
